// File: rtl/wb_stage.sv
// Writeback stage: arbitrates EXU and LSU results onto the register-file write port,
// formats load data and tracks registers with loads still outstanding.
module wb_stage #(
  parameter int unsigned DATA_LEN   = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                exu_valid,
  output logic                exu_ready,
  input  logic                exu_wen,
  input  logic [4:0]          exu_rd,
  input  logic [DATA_LEN-1:0] exu_data,
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic [4:0]          lsu_rd,
  input  logic [2:0]          lsu_funct3,
  input  logic [1:0]          lsu_addr_lo,
  input  logic [DATA_LEN-1:0] lsu_word,
  input  logic                iss_load_valid,
  input  logic [4:0]          iss_load_rd,
  output logic                dest_wen,
  output logic [4:0]          rd,
  output logic [DATA_LEN-1:0] dest_data,
  output logic [31:0]         pend_mask,
  output logic                load_err
);

  localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b100,
    LD_HU = 3'b101
  } load_kind_e;

  logic [CW-1:0]       starve_cnt;
  logic                starve_force;
  logic                lsu_acc;
  logic                exu_acc;
  logic                wb_is_load;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [DATA_LEN-1:0] ld_data;
  logic                ld_err;
  logic [31:0]         pend_set;
  logic [31:0]         pend_clr;

  // Arbitration: LSU wins unless EXU has been refused STARVE_MAX times in a row.
  assign starve_force = (starve_cnt == CW'(STARVE_MAX)) && exu_valid && lsu_valid;
  assign lsu_ready    = ~starve_force;
  assign exu_ready    = starve_force | ~lsu_valid;
  assign lsu_acc      = lsu_valid & lsu_ready;
  assign exu_acc      = exu_valid & exu_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!exu_valid || exu_acc) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_comb begin
    ld_byte = lsu_word[7:0];
    case (lsu_addr_lo)
      2'd0: ld_byte = lsu_word[7:0];
      2'd1: ld_byte = lsu_word[15:8];
      2'd2: ld_byte = lsu_word[23:16];
      2'd3: ld_byte = lsu_word[31:24];
      default: ld_byte = lsu_word[7:0];
    endcase
    ld_half = lsu_addr_lo[1] ? lsu_word[31:16] : lsu_word[15:0];
    ld_data = lsu_word;
    ld_err  = 1'b0;
    case (load_kind_e'(lsu_funct3))
      LD_B:  ld_data = {{(DATA_LEN-8){ld_byte[7]}}, ld_byte};
      LD_BU: ld_data = {{(DATA_LEN-8){1'b0}}, ld_byte};
      LD_H: begin
        ld_data = {{(DATA_LEN-16){ld_half[15]}}, ld_half};
        ld_err  = lsu_addr_lo[0];
      end
      LD_HU: begin
        ld_data = {{(DATA_LEN-16){1'b0}}, ld_half};
        ld_err  = lsu_addr_lo[0];
      end
      LD_W: begin
        ld_data = lsu_word;
        ld_err  = (lsu_addr_lo != 2'd0);
      end
      default: begin
        ld_data = lsu_word;
        ld_err  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest_wen   <= 1'b0;
      rd         <= '0;
      dest_data  <= '0;
      wb_is_load <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      wb_is_load <= lsu_acc;
      load_err   <= lsu_acc & ld_err;
      if (lsu_acc) begin
        dest_wen  <= (lsu_rd != 5'd0);
        rd        <= lsu_rd;
        dest_data <= ld_data;
      end else if (exu_acc) begin
        dest_wen  <= exu_wen && (exu_rd != 5'd0);
        rd        <= exu_rd;
        dest_data <= exu_data;
      end else begin
        dest_wen  <= 1'b0;
      end
    end
  end

  // Clear is applied first so a same-edge set on the same index survives.
  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (iss_load_valid && iss_load_rd != 5'd0) pend_set[iss_load_rd] = 1'b1;
    if (dest_wen && wb_is_load) pend_clr[rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_mask <= '0;
    end else begin
      pend_mask <= ((pend_mask & ~pend_clr) | pend_set) & 32'hFFFF_FFFE;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a behavioural model predicts each cycle's write-port
// state, queues it at drive time and compares after the following clock edge.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exu_valid, exu_ready, exu_wen;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_addr_lo;
  logic [31:0] lsu_word;
  logic        iss_load_valid;
  logic [4:0]  iss_load_rd;
  logic        dest_wen;
  logic [4:0]  rd;
  logic [31:0] dest_data;
  logic [31:0] pend_mask;
  logic        load_err;

  wb_stage #(.DATA_LEN(32), .STARVE_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_wen(exu_wen),
    .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
    .lsu_funct3(lsu_funct3), .lsu_addr_lo(lsu_addr_lo), .lsu_word(lsu_word),
    .iss_load_valid(iss_load_valid), .iss_load_rd(iss_load_rd),
    .dest_wen(dest_wen), .rd(rd), .dest_data(dest_data),
    .pend_mask(pend_mask), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    logic [31:0] pend;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  int unsigned cnt_m;
  logic [31:0] pend_m;
  logic        m_wen, m_isload;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] sb8, sh16;
    sb8  = w >> {a, 3'b000};
    sh16 = w >> {a[1], 4'b0000};
    case (f3)
      3'b000:  return {1'b0, {24{sb8[7]}}, sb8[7:0]};
      3'b100:  return {1'b0, 24'h0, sb8[7:0]};
      3'b001:  return {a[0], {16{sh16[15]}}, sh16[15:0]};
      3'b101:  return {a[0], 16'h0, sh16[15:0]};
      3'b010:  return {a != 2'd0, w};
      default: return {1'b1, w};
    endcase
  endfunction

  task automatic model_reset();
    cnt_m = 0; pend_m = '0; m_wen = 1'b0; m_isload = 1'b0; m_rd = '0; m_data = '0;
    sb.delete();
  endtask

  task automatic idle_inputs();
    exu_valid = 1'b0; exu_wen = 1'b0; exu_rd = '0; exu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_funct3 = '0; lsu_addr_lo = '0; lsu_word = '0;
    iss_load_valid = 1'b0; iss_load_rd = '0;
  endtask

  // Inputs are set by the caller; this checks readies, predicts, clocks once, compares.
  task automatic cycle();
    logic        force_e, lr, er, la, ea;
    logic [32:0] ld;
    exp_t        e, got;
    int unsigned cnt_n;
    #1;
    force_e = (cnt_m == 3) && exu_valid && lsu_valid;
    lr = !force_e;
    er = force_e || !lsu_valid;
    check("lsu_ready", {31'b0, lsu_ready}, {31'b0, lr});
    check("exu_ready", {31'b0, exu_ready}, {31'b0, er});
    la = lsu_valid && lr;
    ea = exu_valid && er;
    cnt_n = (!exu_valid || ea) ? 0 : ((cnt_m < 3) ? cnt_m + 1 : cnt_m);
    e.pend = pend_m;
    if (m_wen && m_isload) e.pend[m_rd] = 1'b0;
    if (iss_load_valid && iss_load_rd != 0) e.pend[iss_load_rd] = 1'b1;
    e.pend[0] = 1'b0;
    e.rd = m_rd; e.data = m_data; e.wen = 1'b0; e.err = 1'b0;
    if (la) begin
      ld = ref_load(lsu_funct3, lsu_addr_lo, lsu_word);
      e.wen = (lsu_rd != 0); e.rd = lsu_rd; e.data = ld[31:0]; e.err = ld[32];
    end else if (ea) begin
      e.wen = exu_wen && (exu_rd != 0); e.rd = exu_rd; e.data = exu_data;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      check("dest_wen", {31'b0, dest_wen}, {31'b0, got.wen});
      check("rd", {27'b0, rd}, {27'b0, got.rd});
      check("dest_data", dest_data, got.data);
      check("load_err", {31'b0, load_err}, {31'b0, got.err});
      check("pend_mask", pend_mask, got.pend);
    end
    cnt_m = cnt_n; pend_m = e.pend; m_wen = e.wen; m_rd = e.rd; m_data = e.data;
    m_isload = la;
  endtask

  task automatic exu(input logic [4:0] r, input logic [31:0] d, input logic w);
    idle_inputs();
    exu_valid = 1'b1; exu_rd = r; exu_data = d; exu_wen = w;
    cycle();
  endtask

  task automatic load(input logic [4:0] r, input logic [2:0] f3, input logic [1:0] a,
                      input logic [31:0] w);
    idle_inputs();
    lsu_valid = 1'b1; lsu_rd = r; lsu_funct3 = f3; lsu_addr_lo = a; lsu_word = w;
    cycle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wen"}, {31'b0, dest_wen}, 32'd0);
    check({tag, "_rd"}, {27'b0, rd}, 32'd0);
    check({tag, "_data"}, dest_data, 32'd0);
    check({tag, "_pend"}, pend_mask, 32'd0);
    check({tag, "_err"}, {31'b0, load_err}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // EXU only, including a write to x0
    exu(5'd5, 32'h1234_5678, 1'b1);
    exu(5'd0, 32'hDEAD_BEEF, 1'b1);
    exu(5'd6, 32'h0BAD_F00D, 1'b0);
    idle_inputs(); cycle();

    // Load formatting, misalignment and illegal encodings
    load(5'd1, 3'b000, 2'd0, 32'h80F1_7F82);
    load(5'd2, 3'b100, 2'd1, 32'h80F1_7F82);
    load(5'd3, 3'b001, 2'd2, 32'h80F1_7F82);
    load(5'd4, 3'b101, 2'd2, 32'h80F1_7F82);
    load(5'd5, 3'b001, 2'd1, 32'h80F1_7F82);
    idle_inputs(); cycle();
    load(5'd6, 3'b010, 2'd0, 32'h80F1_7F82);
    load(5'd7, 3'b010, 2'd2, 32'h80F1_7F82);
    load(5'd8, 3'b011, 2'd0, 32'h1357_9BDF);
    load(5'd9, 3'b000, 2'd3, 32'h80F1_7F82);
    load(5'd0, 3'b100, 2'd3, 32'h80F1_7F82);
    idle_inputs(); cycle();

    // Contention: grants L,L,L,E,L
    for (int i = 0; i < 5; i++) begin
      exu_valid = 1'b1; exu_wen = 1'b1; exu_rd = 5'd20; exu_data = 32'hE000_0000 + i;
      lsu_valid = 1'b1; lsu_rd = 5'(21 + i); lsu_funct3 = 3'b010; lsu_addr_lo = '0;
      lsu_word = 32'h1000_0000 + i;
      cycle();
    end
    idle_inputs(); cycle();

    // Scoreboard set/clear, then same-edge collision and x0 issue
    idle_inputs(); iss_load_valid = 1'b1; iss_load_rd = 5'd10; cycle();
    load(5'd10, 3'b010, 2'd0, 32'hCAFE_0001);
    idle_inputs(); cycle();
    idle_inputs(); cycle();
    idle_inputs(); iss_load_valid = 1'b1; iss_load_rd = 5'd10; cycle();
    load(5'd10, 3'b010, 2'd0, 32'hCAFE_0002);
    idle_inputs(); iss_load_valid = 1'b1; iss_load_rd = 5'd10; cycle();
    idle_inputs(); iss_load_valid = 1'b1; iss_load_rd = 5'd0; cycle();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      exu_valid = 1'($urandom_range(0, 1)); exu_wen = 1'($urandom_range(0, 1));
      exu_rd = 5'($urandom_range(0, 31)); exu_data = $urandom;
      lsu_valid = 1'($urandom_range(0, 1)); lsu_rd = 5'($urandom_range(0, 31));
      lsu_funct3 = 3'($urandom_range(0, 7)); lsu_addr_lo = 2'($urandom_range(0, 3));
      lsu_word = $urandom;
      iss_load_valid = 1'($urandom_range(0, 1)); iss_load_rd = 5'($urandom_range(0, 31));
      cycle();
    end

    // Reset mid-stream with a write pending and x10 outstanding
    idle_inputs(); cycle();
    idle_inputs();
    iss_load_valid = 1'b1; iss_load_rd = 5'd10;
    exu_valid = 1'b1; exu_wen = 1'b1; exu_rd = 5'd7; exu_data = 32'h7777_7777;
    cycle();
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    exu(5'd9, 32'h0000_0099, 1'b1);
    idle_inputs(); cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
